// File: rtl/frame_ctrl_pkg.sv
// Shared definitions for the frame controller: FSM state encoding and
// default sizing constants used by frame_ctrl and frame_phase_cnt.
package frame_ctrl_pkg;

   // Default frame counter width: 2^21 cycles = 13.98 ms at 150 MHz.
   localparam int DEF_CNT_W    = 21;
   localparam int DEF_WID_W    = 8;
   localparam int DEF_FCNT_W   = 32;
   // Marker width of the legacy free-running marker.
   localparam int LEGACY_WIDTH = 100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/frame_phase_cnt.sv
// Loadable wrapping phase counter. Counts 0 .. period-1 and wraps to 0.
// A period of 0 means 2^CNT_W, which falls out of modular arithmetic:
// period - 1 is then all ones. tc_o flags the last phase of a frame.
module frame_phase_cnt
   import frame_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] period_i,
   output logic [CNT_W-1:0] phase_o,
   output logic             tc_o
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] phase_q, phase_d;

   assign tc_o    = (phase_q == (period_i - ONE));
   assign phase_o = phase_q;

   // Next phase: load to 0, otherwise advance and wrap on terminal count.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      phase_d = phase_q;
      if (load_i) begin
         phase_d = '0;
      end else if (en_i) begin
         phase_d = tc_o ? '0 : (phase_q + ONE);
      end
   end

   // Phase register with asynchronous reset to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/frame_ctrl.sv
// Frame controller: IDLE/ARM/RUN/DRAIN FSM producing a periodic frame
// marker (ms_out) of programmable period and width, with a frame counter,
// graceful stop at the frame boundary and a sticky configuration error.
// Build option: define FRAME_CTRL_SYNC_EN to make ARM wait for sync_i;
// otherwise sync_i is unused and ARM enters RUN on the following cycle.
module frame_ctrl
   import frame_ctrl_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int WID_W  = DEF_WID_W,
   parameter int FCNT_W = DEF_FCNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [CNT_W-1:0]  period_i,
   input  logic [WID_W-1:0]  width_i,
   input  logic              sync_i,
   output logic              ms_out,
   output logic              frame_start_o,
   output logic [FCNT_W-1:0] frame_cnt_o,
   output logic              busy_o,
   output logic              cfg_err_o
);

   // Comparison width wide enough for 2^CNT_W and any width value.
   localparam int CMP_W = ((WID_W > CNT_W) ? WID_W : CNT_W) + 1;

   state_e            state_q, state_d;
   logic              pend_q, pend_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [WID_W-1:0]  width_q, width_d;
   logic              ms_q, ms_d;
   logic              fs_q, fs_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              busy_q, busy_d;
   logic              cfg_err_q, cfg_err_d;

   logic              cnt_load, cnt_en, tc;
   logic [CNT_W-1:0]  phase;
   logic [CMP_W-1:0]  eff_period_in;
   logic              cfg_bad, arm_go;

`ifdef FRAME_CTRL_SYNC_EN
   assign arm_go = sync_i;
`else
   logic unused_sync;
   assign unused_sync = sync_i;
   assign arm_go      = 1'b1;
`endif

   // Validity of the configuration presented with start_i.
   assign eff_period_in = (period_i == '0) ? (CMP_W'(1) << CNT_W) : CMP_W'(period_i);
   assign cfg_bad       = (width_i == '0) || (CMP_W'(width_i) >= eff_period_in);
   assign cnt_en        = (state_q == ST_RUN);

   frame_phase_cnt #(.CNT_W(CNT_W)) u_phase (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (cnt_load),
      .en_i     (cnt_en),
      .period_i (period_q),
      .phase_o  (phase),
      .tc_o     (tc)
   );

   // Next-state, marker and counter logic.
   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      period_d  = period_q;
      width_d   = width_q;
      cfg_err_d = cfg_err_q;
      fcnt_d    = fcnt_q;
      cnt_load  = 1'b0;
      ms_d      = 1'b0;
      fs_d      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            pend_d = 1'b0;
            // stop_i together with start_i cancels the request entirely.
            if (start_i && !stop_i) begin
               period_d  = period_i;
               width_d   = width_i;
               fcnt_d    = '0;
               cfg_err_d = cfg_bad;
               if (!cfg_bad) state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            if (stop_i || pend_q) begin
               state_d = ST_IDLE;
               pend_d  = 1'b0;
            end else if (arm_go) begin
               state_d  = ST_RUN;
               cnt_load = 1'b1;
            end
         end
         ST_RUN: begin
            if (stop_i) pend_d = 1'b1;
            // Marker covers the width cycles after phase 0; width < period, so
            // it always ends before the wrap and a stop never truncates it.
            ms_d = (CMP_W'(phase) < CMP_W'(width_q));
            if (phase == '0) begin
               fs_d   = 1'b1;
               fcnt_d = fcnt_q + FCNT_W'(1);
            end
            if (tc && (pend_q || stop_i)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy_d = (state_d != ST_IDLE);

   // State, configuration and registered outputs; reset clears everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pend_q    <= 1'b0;
         period_q  <= '0;
         width_q   <= '0;
         ms_q      <= 1'b0;
         fs_q      <= 1'b0;
         fcnt_q    <= '0;
         busy_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         period_q  <= period_d;
         width_q   <= width_d;
         ms_q      <= ms_d;
         fs_q      <= fs_d;
         fcnt_q    <= fcnt_d;
         busy_q    <= busy_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign ms_out        = ms_q;
   assign frame_start_o = fs_q;
   assign frame_cnt_o   = fcnt_q;
   assign busy_o        = busy_q;
   assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_frame_ctrl.sv
// Directed testbench for frame_ctrl. The DUT is built with CNT_W = 10 so a
// period_i of 0 means 1024 cycles, keeping full-period frames short.
// Works with and without FRAME_CTRL_SYNC_EN defined.
module tb_frame_ctrl;
   import frame_ctrl_pkg::*;

   localparam int CNT_W       = 10;
   localparam int WID_W       = 8;
   localparam int FCNT_W      = 32;
   localparam int FULL_PERIOD = 1 << CNT_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_i = 1'b0;
   logic              stop_i = 1'b0;
   logic [CNT_W-1:0]  period_i = '0;
   logic [WID_W-1:0]  width_i = '0;
   logic              sync_i = 1'b0;
   logic              ms_out;
   logic              frame_start_o;
   logic [FCNT_W-1:0] frame_cnt_o;
   logic              busy_o;
   logic              cfg_err_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   frame_ctrl #(.CNT_W(CNT_W), .WID_W(WID_W), .FCNT_W(FCNT_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .stop_i        (stop_i),
      .period_i      (period_i),
      .width_i       (width_i),
      .sync_i        (sync_i),
      .ms_out        (ms_out),
      .frame_start_o (frame_start_o),
      .frame_cnt_o   (frame_cnt_o),
      .busy_o        (busy_o),
      .cfg_err_o     (cfg_err_o)
   );

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int p, input int w);
      period_i = CNT_W'(p);
      width_i  = WID_W'(w);
      start_i  = 1'b1;
      step();
      start_i  = 1'b0;
   endtask

   // Wait for frame_start_o, pulsing sync_i on cycle sync_at.
   task automatic wait_fs(input int sync_at, input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         sync_i = (i == sync_at);
         if (frame_start_o) found = 1'b1;
         else step();
      end
      sync_i = 1'b0;
   endtask

   // From a frame_start cycle: count marker-high cycles and cycles to the next frame_start.
   task automatic measure_frame(input int budget, output int high, output int span,
                                output bit got_next);
      high = 0; span = 0; got_next = 1'b0;
      for (int i = 0; i < budget && !got_next; i++) begin
         if (ms_out) high++;
         step();
         span++;
         if (frame_start_o) got_next = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      n_checks++; if (ms_out !== 1'b0) begin n_errors++; $display("FAIL reset_ms got=%b exp=0", ms_out); end
      n_checks++; if (frame_start_o !== 1'b0) begin n_errors++; $display("FAIL reset_fs got=%b exp=0", frame_start_o); end
      n_checks++; if (frame_cnt_o !== '0) begin n_errors++; $display("FAIL reset_fcnt got=%0d exp=0", frame_cnt_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      n_checks++; if (cfg_err_o !== 1'b0) begin n_errors++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err_o); end
   endtask

   // Full-length period (period_i = 0) with the legacy marker width.
   task automatic test_legacy();
      bit found, nxt, extra;
      int high, span;
      pulse_start(0, LEGACY_WIDTH);
      n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL legacy_busy got=%b exp=1", busy_o); end
      wait_fs(10, 40, found);
      n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL legacy_first_fs got=%b exp=1", found); end
      n_checks++; if (frame_cnt_o !== 32'd1) begin n_errors++; $display("FAIL legacy_fcnt1 got=%0d exp=1", frame_cnt_o); end
      for (int f = 2; f <= 3; f++) begin
         measure_frame(FULL_PERIOD + 50, high, span, nxt);
         n_checks++; if (high !== LEGACY_WIDTH) begin n_errors++; $display("FAIL legacy_width got=%0d exp=%0d", high, LEGACY_WIDTH); end
         n_checks++; if (span !== FULL_PERIOD || nxt !== 1'b1) begin n_errors++; $display("FAIL legacy_period got=%0d exp=%0d", span, FULL_PERIOD); end
         n_checks++; if (frame_cnt_o !== FCNT_W'(f)) begin n_errors++; $display("FAIL legacy_fcnt got=%0d exp=%0d", frame_cnt_o, f); end
      end
      // Stop on the first marker cycle of frame 3: marker must still run full width.
      high = ms_out ? 1 : 0;
      extra = 1'b0;
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      for (int i = 0; i < FULL_PERIOD + 50 && busy_o; i++) begin
         if (ms_out) high++;
         if (frame_start_o) extra = 1'b1;
         step();
      end
      n_checks++; if (high !== LEGACY_WIDTH) begin n_errors++; $display("FAIL legacy_stop_width got=%0d exp=%0d", high, LEGACY_WIDTH); end
      n_checks++; if (extra !== 1'b0) begin n_errors++; $display("FAIL legacy_extra_frame got=%b exp=0", extra); end
      n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL legacy_stop_idle got=%b exp=0", busy_o); end
      n_checks++; if (frame_cnt_o !== 32'd3) begin n_errors++; $display("FAIL legacy_stop_fcnt got=%0d exp=3", frame_cnt_o); end
   endtask

   task automatic test_cfg_err();
      bit bad;
      pulse_start(16, 16);
      n_checks++; if (cfg_err_o !== 1'b1) begin n_errors++; $display("FAIL cfg_eq_err got=%b exp=1", cfg_err_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL cfg_eq_busy got=%b exp=0", busy_o); end
      bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         sync_i = (i == 3);
         if (ms_out || busy_o) bad = 1'b1;
         step();
      end
      sync_i = 1'b0;
      n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL cfg_eq_quiet got=%b exp=0", bad); end
      pulse_start(20, 0);
      n_checks++; if (cfg_err_o !== 1'b1) begin n_errors++; $display("FAIL cfg_w0_err got=%b exp=1", cfg_err_o); end
      // width = period - 1 is the largest valid width; a valid start clears the flag.
      pulse_start(16, 15);
      n_checks++; if (cfg_err_o !== 1'b0 || busy_o !== 1'b1) begin n_errors++; $display("FAIL cfg_max_ok got=%b%b exp=01", cfg_err_o, busy_o); end
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL arm_stop_idle got=%b exp=0", busy_o); end
   endtask

   // period 20 width 5, stray start/sync in RUN, stop at phase 3 of frame 2.
   task automatic test_stop_drain();
      bit found, nxt;
      int high, span, h, extra, idle_at;
      pulse_start(20, 5);
      wait_fs(0, 10, found);
      n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL drain_first_fs got=%b exp=1", found); end
      h = ms_out ? 1 : 0;
      start_i = 1'b1; period_i = CNT_W'(30); width_i = WID_W'(9); sync_i = 1'b1;
      step();
      start_i = 1'b0; sync_i = 1'b0;
      measure_frame(40, high, span, nxt);
      n_checks++; if (high + h !== 5) begin n_errors++; $display("FAIL drain_width1 got=%0d exp=5", high + h); end
      n_checks++; if (span + 1 !== 20 || nxt !== 1'b1) begin n_errors++; $display("FAIL drain_period1 got=%0d exp=20", span + 1); end
      n_checks++; if (frame_cnt_o !== 32'd2) begin n_errors++; $display("FAIL drain_fcnt2 got=%0d exp=2", frame_cnt_o); end
      h = 0; extra = 0; idle_at = -1;
      for (int k = 0; k < 40 && idle_at < 0; k++) begin
         stop_i = (k == 2);
         if (!busy_o) idle_at = k;
         else begin
            if (ms_out) h++;
            if (k > 0 && frame_start_o) extra++;
            step();
         end
      end
      stop_i = 1'b0;
      n_checks++; if (h !== 5) begin n_errors++; $display("FAIL drain_width2 got=%0d exp=5", h); end
      n_checks++; if (extra !== 0) begin n_errors++; $display("FAIL drain_extra got=%0d exp=0", extra); end
      n_checks++; if (idle_at !== 20) begin n_errors++; $display("FAIL drain_idle_cycle got=%0d exp=20", idle_at); end
      n_checks++; if (frame_cnt_o !== 32'd2 || ms_out !== 1'b0) begin n_errors++; $display("FAIL drain_final got=%0d/%b exp=2/0", frame_cnt_o, ms_out); end
   endtask

   task automatic test_start_stop();
      period_i = CNT_W'(16); width_i = WID_W'(16);
      start_i = 1'b1; stop_i = 1'b1;
      step();
      start_i = 1'b0; stop_i = 1'b0;
      n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL ss_busy got=%b exp=0", busy_o); end
      n_checks++; if (cfg_err_o !== 1'b0) begin n_errors++; $display("FAIL ss_cfg_err got=%b exp=0", cfg_err_o); end
      n_checks++; if (frame_cnt_o !== 32'd2) begin n_errors++; $display("FAIL ss_fcnt got=%0d exp=2", frame_cnt_o); end
      period_i = CNT_W'(20); width_i = WID_W'(5);
      start_i = 1'b1; stop_i = 1'b1;
      step();
      start_i = 1'b0; stop_i = 1'b0;
      n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL ss_valid_busy got=%b exp=0", busy_o); end
   endtask

   task automatic test_reset_mid();
      bit found, bad;
      pulse_start(20, 5);
      wait_fs(0, 10, found);
      step();
      n_checks++; if (ms_out !== 1'b1 || found !== 1'b1) begin n_errors++; $display("FAIL rmid_marker got=%b exp=1", ms_out); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (ms_out !== 1'b0) begin n_errors++; $display("FAIL rmid_ms got=%b exp=0", ms_out); end
      n_checks++; if (frame_cnt_o !== '0 || busy_o !== 1'b0 || cfg_err_o !== 1'b0 || frame_start_o !== 1'b0)
         begin n_errors++; $display("FAIL rmid_outputs got=%0d%b%b%b exp=0000", frame_cnt_o, busy_o, cfg_err_o, frame_start_o); end
      step();
      rst_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (busy_o || ms_out) bad = 1'b1;
      end
      n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL rmid_stays_idle got=%b exp=0", bad); end
   endtask

`ifdef FRAME_CTRL_SYNC_EN
   task automatic test_arm_wait();
      bit bad;
      pulse_start(20, 5);
      bad = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (ms_out || frame_start_o || !busy_o) bad = 1'b1;
         step();
      end
      n_checks++; if (bad !== 1'b0 || busy_o !== 1'b1) begin n_errors++; $display("FAIL arm_wait got=%b%b exp=01", bad, busy_o); end
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL arm_wait_stop got=%b exp=0", busy_o); end
   endtask
`else
   task automatic test_arm_wait();
      pulse_start(20, 5);
      n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL nosync_busy got=%b exp=1", busy_o); end
      step();
      step();
      n_checks++; if (frame_start_o !== 1'b1 || ms_out !== 1'b1) begin n_errors++; $display("FAIL nosync_fs got=%b%b exp=11", frame_start_o, ms_out); end
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      for (int i = 0; i < 30 && busy_o; i++) step();
      n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL nosync_stop got=%b exp=0", busy_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_legacy();
      test_cfg_err();
      test_stop_drain();
      test_start_stop();
      test_reset_mid();
      test_arm_wait();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
